// File: rtl/rmc_seq_pkg.sv
// Shared types and helpers for the RMC enable sequencer: FSM state encoding,
// default step gaps and the thermometer-mask builder.
package rmc_seq_pkg;

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_UP   = 2'd1,
    S_ON   = 2'd2,
    S_DOWN = 2'd3
  } seq_state_t;

  localparam int unsigned MAX_CH = 16;

  localparam logic [15:0] DEFAULT_ON_GAP  = 16'd2400;
  localparam logic [15:0] DEFAULT_OFF_GAP = 16'd2400;

  // Returns a mask with the lowest 'count' bits set (count = 0..MAX_CH).
  function automatic logic [MAX_CH-1:0] thermo_mask(input logic [4:0] count);
    logic [MAX_CH-1:0] m;
    for (int i = 0; i < MAX_CH; i++) begin
      m[i] = (i < int'(count));
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_gap_timer.sv
// Tick-driven gap timer shared by every sequencing step. Expires on the
// gap-th iTick after the last clear; the count never runs past gap-1.
module seq_gap_timer #(
  parameter int unsigned DLY_WIDTH = 16
) (
  input  logic                 clk_in,
  input  logic                 iRst_n,
  input  logic                 clear,
  input  logic                 iTick,
  input  logic [DLY_WIDTH-1:0] gap,
  output logic                 expire
);

  logic [DLY_WIDTH-1:0] cnt;
  logic                 at_limit;

  assign at_limit = (cnt >= gap - DLY_WIDTH'(1));

  // A tick coinciding with a clear is swallowed: the step that clears the
  // timer restarts the gap from zero.
  assign expire = iTick && !clear && at_limit;

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk_in or negedge iRst_n) begin
    if (!iRst_n) begin
      cnt <= '0;
    end else if (clear || expire) begin
      cnt <= '0;
    end else if (iTick && !at_limit) begin
      cnt <= cnt + DLY_WIDTH'(1);
    end
  end

endmodule

// File: rtl/rmc_enable_sequencer.sv
// Steps a bank of RMC enables on (bit 0 first) and off (top bit first) with a
// programmable tick gap, plus bypass and a latched fault lockout.
module rmc_enable_sequencer
  import rmc_seq_pkg::*;
#(
  parameter int unsigned          NUM_CH    = 4,
  parameter int unsigned          DLY_WIDTH = 16,
  parameter logic [DLY_WIDTH-1:0] ON_GAP    = DLY_WIDTH'(DEFAULT_ON_GAP),
  parameter logic [DLY_WIDTH-1:0] OFF_GAP   = DLY_WIDTH'(DEFAULT_OFF_GAP)
) (
  input  logic              clk_in,
  input  logic              iRst_n,
  input  logic              iTick,
  input  logic              iEnable_req,
  input  logic              iSeq_config,
  input  logic              iFault,
  output logic [NUM_CH-1:0] oCh_enable,
  output logic              oSeq_busy,
  output logic              oSeq_done,
  output logic              oFault_latched
);

  localparam int unsigned       IDX_W   = $clog2(NUM_CH);
  localparam logic [IDX_W-1:0]  IDX_ONE = IDX_W'(1);
  localparam logic [IDX_W-1:0]  LAST    = IDX_W'(NUM_CH - 1);

  seq_state_t           state;
  logic [IDX_W-1:0]     idx;
  logic [4:0]           idx_ext;
  logic [NUM_CH-1:0]    mask;
  logic                 busy;
  logic                 done;
  logic                 fault_latched;
  logic                 timer_clear;
  logic                 expire;
  logic [DLY_WIDTH-1:0] gap;

  function automatic logic [NUM_CH-1:0] mask_of(input logic [4:0] count);
    return NUM_CH'(thermo_mask(count));
  endfunction

  assign idx_ext = 5'(idx);
  assign gap     = (state == S_DOWN) ? OFF_GAP : ON_GAP;

  // The timer only runs while a step is pending in the current direction;
  // idle states, reversals, bypass and fault all hold it at zero.
  // NOTE: the default assignment first guarantees no latch is inferred.
  always_comb begin
    timer_clear = 1'b1;
    if (!iFault && !fault_latched && iSeq_config) begin
      case (state)
        S_UP:    timer_clear = !iEnable_req;
        S_DOWN:  timer_clear = iEnable_req;
        default: timer_clear = 1'b1;
      endcase
    end
  end

  seq_gap_timer #(
    .DLY_WIDTH (DLY_WIDTH)
  ) u_gap_timer (
    .clk_in (clk_in),
    .iRst_n (iRst_n),
    .clear  (timer_clear),
    .iTick  (iTick),
    .gap    (gap),
    .expire (expire)
  );

  // In S_UP idx is the highest channel on; in S_DOWN it is the channel most
  // recently turned off, so the mask always holds a thermometer code.
  always_ff @(posedge clk_in or negedge iRst_n) begin
    if (!iRst_n) begin
      state         <= S_OFF;
      idx           <= '0;
      mask          <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      fault_latched <= 1'b0;
    end else begin
      done <= 1'b0;
      if (iFault) begin
        state         <= S_OFF;
        idx           <= '0;
        mask          <= '0;
        busy          <= 1'b0;
        fault_latched <= 1'b1;
      end else if (fault_latched) begin
        if (!iEnable_req) begin
          fault_latched <= 1'b0;
        end
      end else if (!iSeq_config) begin
        state <= iEnable_req ? S_ON : S_OFF;
        idx   <= iEnable_req ? LAST : '0;
        mask  <= {NUM_CH{iEnable_req}};
        busy  <= 1'b0;
      end else begin
        case (state)
          S_OFF: begin
            if (iEnable_req) begin
              idx   <= '0;
              mask  <= mask_of(5'd1);
              state <= S_UP;
              busy  <= 1'b1;
            end
          end
          S_UP: begin
            if (!iEnable_req) begin
              mask <= mask_of(idx_ext);
              if (idx == '0) begin
                state <= S_OFF;
                busy  <= 1'b0;
              end else begin
                state <= S_DOWN;
              end
            end else if (expire) begin
              idx  <= idx + IDX_ONE;
              mask <= mask_of(idx_ext + 5'd2);
              if (idx + IDX_ONE == LAST) begin
                state <= S_ON;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
          S_ON: begin
            if (!iEnable_req) begin
              idx   <= LAST;
              mask  <= mask_of(5'(LAST));
              state <= S_DOWN;
              busy  <= 1'b1;
            end
          end
          S_DOWN: begin
            if (iEnable_req) begin
              mask <= mask_of(idx_ext + 5'd1);
              if (idx == LAST) begin
                state <= S_ON;
                busy  <= 1'b0;
              end else begin
                state <= S_UP;
              end
            end else if (expire) begin
              idx  <= idx - IDX_ONE;
              mask <= mask_of(idx_ext - 5'd1);
              if (idx == IDX_ONE) begin
                state <= S_OFF;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
          default: state <= S_OFF;
        endcase
      end
    end
  end

  assign oCh_enable     = mask;
  assign oSeq_busy      = busy;
  assign oSeq_done      = done;
  assign oFault_latched = fault_latched;

endmodule

// File: tb/tb_rmc_enable_sequencer.sv
// Self-checking bench: directed vector table, hand-written multi-cycle
// sequences, then random stimulus against a channel-count reference model.
module tb_rmc_enable_sequencer;

  localparam int N   = 4;
  localparam int ON  = 3;
  localparam int OFF = 2;

  logic         clk_in = 1'b0;
  logic         iRst_n;
  logic         iTick;
  logic         iEnable_req;
  logic         iSeq_config;
  logic         iFault;
  logic [N-1:0] oCh_enable;
  logic         oSeq_busy;
  logic         oSeq_done;
  logic         oFault_latched;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_in = ~clk_in;

  rmc_enable_sequencer #(
    .NUM_CH    (N),
    .DLY_WIDTH (16),
    .ON_GAP    (16'd3),
    .OFF_GAP   (16'd2)
  ) dut (
    .clk_in         (clk_in),
    .iRst_n         (iRst_n),
    .iTick          (iTick),
    .iEnable_req    (iEnable_req),
    .iSeq_config    (iSeq_config),
    .iFault         (iFault),
    .oCh_enable     (oCh_enable),
    .oSeq_busy      (oSeq_busy),
    .oSeq_done      (oSeq_done),
    .oFault_latched (oFault_latched)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: number of lit channels plus direction of travel.
  int m_lit;
  int m_dir;
  int m_ticks;
  bit m_latched;
  bit m_done;

  task automatic model_reset();
    m_lit = 0; m_dir = 0; m_ticks = 0; m_latched = 0; m_done = 0;
  endtask

  task automatic model_step();
    int target;
    int want;
    m_done = 0;
    if (iFault === 1'b1) begin
      m_lit = 0; m_dir = 0; m_ticks = 0; m_latched = 1;
    end else if (m_latched) begin
      if (iEnable_req === 1'b0) m_latched = 0;
    end else if (iSeq_config === 1'b0) begin
      m_lit = (iEnable_req === 1'b1) ? N : 0;
      m_dir = 0; m_ticks = 0;
    end else begin
      target = (iEnable_req === 1'b1) ? N : 0;
      want   = (iEnable_req === 1'b1) ? 1 : -1;
      if (m_lit == target) begin
        m_dir = 0; m_ticks = 0;
      end else if (m_dir != want) begin
        m_lit   = m_lit + want;
        m_ticks = 0;
        m_dir   = (m_lit == target) ? 0 : want;
      end else if (iTick === 1'b1) begin
        m_ticks++;
        if (m_ticks == ((want > 0) ? ON : OFF)) begin
          m_lit   = m_lit + want;
          m_ticks = 0;
          if (m_lit == target) begin
            m_dir  = 0;
            m_done = 1;
          end
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [N-1:0] nxt;
    nxt = oCh_enable + N'(1);
    check({tag, ".mask"},   32'(oCh_enable),     32'((1 << m_lit) - 1));
    check({tag, ".busy"},   32'(oSeq_busy),      32'(m_dir != 0));
    check({tag, ".done"},   32'(oSeq_done),      32'(m_done));
    check({tag, ".fault"},  32'(oFault_latched), 32'(m_latched));
    check({tag, ".thermo"}, 32'((oCh_enable & nxt) == '0), 32'(1));
  endtask

  task automatic cycle(input bit tick, input bit req, input bit cfg, input bit fault);
    iTick = tick; iEnable_req = req; iSeq_config = cfg; iFault = fault;
    @(posedge clk_in);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    iRst_n = 1'b0;
    iTick = 0; iEnable_req = 0; iSeq_config = 1; iFault = 0;
    repeat (2) @(posedge clk_in);
    #1;
    model_reset();
    @(negedge clk_in);
    iRst_n = 1'b1;
  endtask

  typedef struct {
    bit         tick;
    bit         req;
    bit         cfg;
    bit         fault;
    logic [3:0] mask;
    bit         busy;
    bit         done;
    bit         lat;
  } vec_t;

  function automatic vec_t mk(input bit t, input bit r, input bit c, input bit f,
                              input logic [3:0] m, input bit b, input bit d, input bit l);
    vec_t v;
    v.tick = t; v.req = r; v.cfg = c; v.fault = f;
    v.mask = m; v.busy = b; v.done = d; v.lat = l;
    return v;
  endfunction

  vec_t vecs [17];

  initial begin
    bit req_r;
    bit cfg_r;

    // tick req cfg fault | mask busy done latched (after the edge)
    vecs[0]  = mk(0, 1, 0, 0, 4'hF, 0, 0, 0);  // bypass on
    vecs[1]  = mk(1, 1, 0, 0, 4'hF, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 4'h0, 0, 0, 0);  // bypass off
    vecs[3]  = mk(0, 1, 0, 0, 4'hF, 0, 0, 0);
    vecs[4]  = mk(0, 1, 1, 0, 4'hF, 0, 0, 0);  // back to sequenced, resting in S_ON
    vecs[5]  = mk(0, 0, 1, 0, 4'h7, 1, 0, 0);  // first down step
    vecs[6]  = mk(1, 0, 1, 0, 4'h7, 1, 0, 0);
    vecs[7]  = mk(1, 0, 1, 0, 4'h3, 1, 0, 0);  // OFF_GAP=2 ticks
    vecs[8]  = mk(0, 1, 1, 0, 4'h7, 1, 0, 0);  // reversal re-enables ch2
    vecs[9]  = mk(0, 1, 1, 1, 4'h0, 0, 0, 1);  // fault
    vecs[10] = mk(0, 1, 1, 0, 4'h0, 0, 0, 1);  // request ignored while latched
    vecs[11] = mk(1, 1, 1, 0, 4'h0, 0, 0, 1);
    vecs[12] = mk(0, 0, 1, 0, 4'h0, 0, 0, 0);  // latch released by req=0
    vecs[13] = mk(0, 1, 1, 0, 4'h1, 1, 0, 0);
    vecs[14] = mk(0, 0, 1, 0, 4'h0, 0, 0, 0);  // reversal at idx 0, no done
    vecs[15] = mk(0, 1, 0, 1, 4'h0, 0, 0, 1);  // fault outranks bypass
    vecs[16] = mk(0, 0, 0, 0, 4'h0, 0, 0, 0);

    iRst_n = 1'b0;
    iTick = 0; iEnable_req = 0; iSeq_config = 1; iFault = 0;
    repeat (2) @(posedge clk_in);
    #1;
    check("reset.mask",  32'(oCh_enable),     32'(0));
    check("reset.busy",  32'(oSeq_busy),      32'(0));
    check("reset.done",  32'(oSeq_done),      32'(0));
    check("reset.fault", 32'(oFault_latched), 32'(0));
    model_reset();
    @(negedge clk_in);
    iRst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      cycle(vecs[i].tick, vecs[i].req, vecs[i].cfg, vecs[i].fault);
      check($sformatf("vec%0d.mask", i),  32'(oCh_enable),     32'(vecs[i].mask));
      check($sformatf("vec%0d.busy", i),  32'(oSeq_busy),      32'(vecs[i].busy));
      check($sformatf("vec%0d.done", i),  32'(oSeq_done),      32'(vecs[i].done));
      check($sformatf("vec%0d.fault", i), 32'(oFault_latched), 32'(vecs[i].lat));
    end

    // Power-up, tick every other clock: steps land on clocks 1, 7, 13, 19.
    do_reset();
    for (int k = 1; k <= 22; k++) begin
      logic [3:0] exp_m;
      cycle(k % 2 == 1, 1, 1, 0);
      exp_m = (k < 7) ? 4'h1 : (k < 13) ? 4'h3 : (k < 19) ? 4'h7 : 4'hF;
      check($sformatf("up%0d.mask", k), 32'(oCh_enable), 32'(exp_m));
      check($sformatf("up%0d.done", k), 32'(oSeq_done),  32'(k == 19));
      check_model($sformatf("up%0d", k));
    end

    // Power-down from S_ON with OFF_GAP=2.
    for (int k = 1; k <= 14; k++) begin
      logic [3:0] exp_m;
      cycle(k % 2 == 1, 0, 1, 0);
      exp_m = (k < 5) ? 4'h7 : (k < 9) ? 4'h3 : (k < 13) ? 4'h1 : 4'h0;
      check($sformatf("dn%0d.mask", k), 32'(oCh_enable), 32'(exp_m));
      check($sformatf("dn%0d.done", k), 32'(oSeq_done),  32'(k == 13));
      check($sformatf("dn%0d.busy", k), 32'(oSeq_busy),  32'(k < 13));
    end

    // Reversals in both directions.
    cycle(0, 1, 1, 0);
    repeat (3) cycle(1, 1, 1, 0);
    check("rev.up_mask", 32'(oCh_enable), 32'(4'h3));
    cycle(0, 0, 1, 0);
    check("rev.drop_mask", 32'(oCh_enable), 32'(4'h1));
    check("rev.drop_busy", 32'(oSeq_busy),  32'(1));
    cycle(0, 1, 1, 0);
    check("rev.raise_mask", 32'(oCh_enable), 32'(4'h3));
    cycle(0, 0, 1, 0);
    check_model("rev.again");
    cycle(1, 0, 1, 0);
    check("rev.hold_mask", 32'(oCh_enable), 32'(4'h1));
    cycle(1, 0, 1, 0);
    check("rev.off_mask", 32'(oCh_enable), 32'(4'h0));
    check("rev.off_done", 32'(oSeq_done),  32'(1));

    // Asynchronous reset mid power-up, then a clean restart.
    cycle(0, 1, 1, 0);
    repeat (3) cycle(1, 1, 1, 0);
    check("arst.pre_mask", 32'(oCh_enable), 32'(4'h3));
    #2;
    iRst_n = 1'b0;
    #1;
    check("arst.mask", 32'(oCh_enable), 32'(0));
    check("arst.busy", 32'(oSeq_busy),  32'(0));
    iEnable_req = 0;
    model_reset();
    @(negedge clk_in);
    iRst_n = 1'b1;
    cycle(0, 1, 1, 0);
    check("arst.restart_mask", 32'(oCh_enable), 32'(4'h1));
    check("arst.restart_busy", 32'(oSeq_busy),  32'(1));

    // Random stimulus against the reference model.
    req_r = 1;
    cfg_r = 1;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 19) == 0) req_r = !req_r;
      if ($urandom_range(0, 199) == 0) cfg_r = !cfg_r;
      cycle($urandom_range(0, 1) == 1, req_r, cfg_r, $urandom_range(0, 119) == 0);
      check_model($sformatf("rnd%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
